// File: rtl/div_iter_radix2.sv
// rtl/div_iter_radix2.sv - radix-2 restoring divider producing {HI,LO} for DIV/DIVU
// One quotient bit per cycle on magnitudes; signs are restored when the result is loaded.
module div_iter_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               cancel_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   dividend_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               div0_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   dvd_q;
   logic [WIDTH-1:0]   dvsr_q;
   logic [WIDTH-1:0]   rem_q;
   logic               qneg_q;
   logic               rneg_q;
   logic               busy_q;
   logic               done_q;
   logic               div0_q;
   logic [2*WIDTH-1:0] result_q;

   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     sub;
   logic               qbit;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quot_d;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign sa    = signed_i & dividend_i[WIDTH-1];
   assign sb    = signed_i & divisor_i[WIDTH-1];
   assign abs_a = sa ? -dividend_i : dividend_i;
   assign abs_b = sb ? -divisor_i : divisor_i;

   // rem_sh < 2*dvsr, so rem_sh - dvsr always fits a signed WIDTH+1 value and its MSB is the borrow.
   always_comb begin
      rem_sh   = {rem_q, dvd_q[WIDTH-1]};
      sub      = rem_sh - {1'b0, dvsr_q};
      qbit     = ~sub[WIDTH];
      rem_d    = qbit ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quot_d   = {dvd_q[WIDTH-2:0], qbit};
      quot_fix = qneg_q ? -quot_d : quot_d;
      rem_fix  = rneg_q ? -rem_d : rem_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvsr_q   <= '0;
         rem_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
         result_q <= '0;
      end else if (cancel_i) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  dvd_q  <= abs_a;
                  dvsr_q <= abs_b;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  qneg_q <= sa ^ sb;
                  rneg_q <= sa;
                  busy_q <= 1'b1;
                  if (divisor_i == '0) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     div0_q   <= 1'b1;
                     result_q <= {dividend_i, {WIDTH{1'b1}}};
                  end else begin
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               rem_q <= rem_d;
               dvd_q <= quot_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  div0_q   <= 1'b0;
                  result_q <= {rem_fix, quot_fix};
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
   assign div0_o   = div0_q;

endmodule
